chan_ctrl: RTL

CHAN_CTRL -- requirements
Module: chan_ctrl

---
 rtl/chan_pkg.sv | 44 ++++
 rtl/chan_tick_gen.sv | 31 +++
 rtl/chan_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/chan_pkg.sv
// Shared types, limits and helpers for the channel controller.
package chan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_APPLY
  } state_e;

  localparam logic [3:0] NFREQ_MIN  = 4'd1;
  localparam logic [3:0] NFREQ_MAX  = 4'd12;
  localparam logic [4:0] NQUANT_MIN = 5'd1;
  localparam logic [4:0] NQUANT_MAX = 5'd18;

  localparam int SW_FILTER   = 0;
  localparam int SW_DOWNSAMP = 1;
  localparam int SW_REQUANT  = 2;
  localparam int SW_INTERP   = 3;

  function automatic logic nfreq_bad(input logic [3:0] v);
    return (v < NFREQ_MIN) || (v > NFREQ_MAX);
  endfunction

  function automatic logic nquant_bad(input logic [4:0] v);
    return (v < NQUANT_MIN) || (v > NQUANT_MAX);
  endfunction

  function automatic logic [3:0] legal_nfreq(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (v < NFREQ_MIN) r = NFREQ_MIN;
    if (v > NFREQ_MAX) r = NFREQ_MAX;
    return r;
  endfunction

  function automatic logic [4:0] legal_nquant(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (v < NQUANT_MIN) r = NQUANT_MIN;
    if (v > NQUANT_MAX) r = NQUANT_MAX;
    return r;
  endfunction

endpackage

// File: rtl/chan_tick_gen.sv
// Divides the master clock down to the one-cycle 48 kHz sample tick.
module chan_tick_gen #(
  parameter int unsigned CLK_DIV = 2083
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o,
  output logic data_en_o
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        de_q;

  // tick_o is the cycle before data_en, so frame logic can register alongside it
  assign tick_o    = (cnt_q == LAST);
  assign cnt_d     = tick_o ? '0 : cnt_q + 16'd1;
  assign data_en_o = de_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      de_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      de_q  <= tick_o;
    end
  end

endmodule

// File: rtl/chan_ctrl.sv
// Channel controller: sample tick, decimation framing, frame-aligned config apply.
// Define CHAN_CTRL_ERR_EN to add the sticky cfg_err port.
module chan_ctrl
  import chan_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2083,
  parameter int unsigned NFREQ_RST  = 1,
  parameter int unsigned NQUANT_RST = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_wr,
  input  logic [3:0] cfg_nfreq,
  input  logic [4:0] cfg_nquant,
  input  logic [3:0] cfg_sw,
  output logic       data_en,
  output logic [3:0] Nfreq,
  output logic [4:0] Nquant,
  output logic [3:0] switches,
  output logic       frame_start,
  output logic       cfg_busy
`ifdef CHAN_CTRL_ERR_EN
  ,
  output logic       cfg_err
`endif
);

  logic tick;

  chan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock     (clock),
    .reset     (reset),
    .tick_o    (tick),
    .data_en_o (data_en)
  );

  state_e     state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic       fs_q, fs_d;
  logic [3:0] sh_nf_q, sh_nf_d;
  logic [4:0] sh_nq_q, sh_nq_d;
  logic [3:0] sh_sw_q, sh_sw_d;
  logic [3:0] nf_q, nf_d;
  logic [4:0] nq_q, nq_d;
  logic [3:0] sw_q, sw_d;
  logic       last;

  assign last        = (phase_q == nf_q - 4'd1);
  assign frame_start = fs_q;
  assign Nfreq       = nf_q;
  assign Nquant      = nq_q;
  assign switches    = sw_q;
  assign cfg_busy    = (state_q == ST_PENDING);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fs_d    = 1'b0;
    sh_nf_d = sh_nf_q;
    sh_nq_d = sh_nq_q;
    sh_sw_d = sh_sw_q;
    nf_d    = nf_q;
    nq_d    = nq_q;
    sw_d    = sw_q;

    if (tick) begin
      phase_d = last ? 4'd0 : phase_q + 4'd1;
      fs_d    = last;
    end

    // Capturing in every state lets a write on the apply edge pass straight through
    if (cfg_wr) begin
      sh_nf_d = legal_nfreq(cfg_nfreq);
      sh_nq_d = legal_nquant(cfg_nquant);
      sh_sw_d = cfg_sw;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_wr) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (fs_q) begin
          nf_d    = sh_nf_d;
          nq_d    = sh_nq_d;
          sw_d    = sh_sw_d;
          phase_d = 4'd0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_d = cfg_wr ? ST_PENDING : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      fs_q    <= 1'b0;
      sh_nf_q <= '0;
      sh_nq_q <= '0;
      sh_sw_q <= '0;
      nf_q    <= 4'(NFREQ_RST);
      nq_q    <= 5'(NQUANT_RST);
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fs_q    <= fs_d;
      sh_nf_q <= sh_nf_d;
      sh_nq_q <= sh_nq_d;
      sh_sw_q <= sh_sw_d;
      nf_q    <= nf_d;
      nq_q    <= nq_d;
      sw_q    <= sw_d;
    end
  end

`ifdef CHAN_CTRL_ERR_EN
  logic err_q, err_d;

  assign err_d   = err_q |
                   (cfg_wr & (nfreq_bad(cfg_nfreq) | nquant_bad(cfg_nquant)));
  assign cfg_err = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

endmodule
